// File: rtl/seg_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_pkg
//   Shared definitions for the multiplexed seven-segment scan controller.
//   - scan_state_t : scan FSM states (IDLE, LIT, GAP)
//   - SEG_TABLE    : hex nibble -> active-high segment pattern, bit6=a .. bit0=g
// -----------------------------------------------------------------------------
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LIT  = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
//   Combinational hex-nibble to seven-segment decoder.
//   Ports:
//     hex : in  [3:0]  nibble to display
//     seg : out [6:0]  active-high segments, bit6=a .. bit0=g
// -----------------------------------------------------------------------------
module seg_hex_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for an N_DIG-digit seven-segment display.
//   Each digit is lit for DIV cycles, followed by DEAD all-off cycles (skipped
//   when DEAD=0). New display values arrive through a valid/ready handshake
//   and are only applied at a frame start, so a frame never mixes values.
//
//   Handshake: a transfer happens on any rising edge where wr_valid and
//   wr_ready are both 1. wr_valid may be held or dropped freely; wr_ready is
//   low while a value waits in the pending register and returns high the
//   cycle after that value is copied to the active register.
//
//   Ports:
//     clk      : in   clock, rising edge
//     reset    : in   synchronous, active-high
//     en       : in   display enable (0 forces IDLE on the next edge)
//     blank_lz : in   leading-zero blanking enable
//     wr_valid : in   new display value offered
//     wr_ready : out  value can be accepted
//     wr_data  : in   [4*N_DIG-1:0] hex digits, digit 0 in bits [3:0]
//     an       : out  [N_DIG-1:0] active-low digit selects (registered)
//     seg      : out  [6:0] active-high segments (registered)
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int N_DIG = 4,
    parameter int DIV   = 50000,
    parameter int DEAD  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               blank_lz,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [4*N_DIG-1:0] wr_data,
    output logic [N_DIG-1:0]   an,
    output logic [6:0]         seg
);

    localparam int CMAX      = (DIV > DEAD) ? DIV : DEAD;
    localparam int CW        = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int DW        = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int DIV_LAST  = (DIV > 0) ? DIV - 1 : 0;
    localparam int DEAD_LAST = (DEAD > 0) ? DEAD - 1 : 0;

    scan_state_t        state, nxt_state;
    logic [DW-1:0]      digit, nxt_digit, digit_inc;
    logic [CW-1:0]      cnt, nxt_cnt;
    logic [4*N_DIG-1:0] active, pending, nxt_active;
    logic               pend_valid;
    logic               frame_start, copy;
    logic [3:0]         nib;
    logic [DW-1:0]      hi_nz;
    logic               blank;
    logic [6:0]         dec_seg;
    logic [N_DIG-1:0]   nxt_an;
    logic [6:0]         nxt_seg;

    assign wr_ready  = !pend_valid;
    assign digit_inc = (digit == DW'(N_DIG - 1)) ? '0 : digit + 1'b1;

    // Next-state logic
    always_comb begin
        nxt_state = state;
        nxt_digit = digit;
        nxt_cnt   = cnt;
        case (state)
            IDLE: begin
                nxt_state = LIT;
                nxt_digit = '0;
                nxt_cnt   = '0;
            end
            LIT: begin
                if (cnt == CW'(DIV_LAST)) begin
                    nxt_cnt = '0;
                    if (DEAD == 0) begin
                        nxt_digit = digit_inc;
                    end else begin
                        nxt_state = GAP;
                    end
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == CW'(DEAD_LAST)) begin
                    nxt_state = LIT;
                    nxt_digit = digit_inc;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_digit = '0;
                nxt_cnt   = '0;
            end
        endcase
        // Disable wins over everything; re-enable always restarts at digit 0.
        if (!en) begin
            nxt_state = IDLE;
            nxt_digit = '0;
            nxt_cnt   = '0;
        end
    end

    // A frame starts on any edge that lands in LIT for digit 0 from somewhere
    // other than the middle of that same slot (covers DEAD=0, N_DIG=1 wrap).
    assign frame_start = (nxt_state == LIT) && (nxt_digit == '0) &&
                         ((state != LIT) || (cnt == CW'(DIV_LAST)));
    assign copy        = pend_valid && ((state == IDLE) || frame_start);
    assign nxt_active  = copy ? pending : active;

    // Outputs are registered, so decode from the value and digit that will be
    // current after this edge.
    always_comb begin
        nib   = 4'h0;
        hi_nz = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (nxt_digit == DW'(i)) nib = nxt_active[i*4 +: 4];
            if (nxt_active[i*4 +: 4] != 4'h0) hi_nz = DW'(i);
        end
    end

    // Digit 0 is never above hi_nz, so it is never blanked.
    assign blank = blank_lz && (nxt_digit > hi_nz);

    seg_hex_decode u_decode (
        .hex (nib),
        .seg (dec_seg)
    );

    always_comb begin
        nxt_an  = '1;
        nxt_seg = '0;
        if (nxt_state == LIT && !blank) begin
            for (int i = 0; i < N_DIG; i++) begin
                if (nxt_digit == DW'(i)) nxt_an[i] = 1'b0;
            end
            nxt_seg = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            digit      <= '0;
            cnt        <= '0;
            active     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            an         <= '1;
            seg        <= '0;
        end else begin
            state  <= nxt_state;
            digit  <= nxt_digit;
            cnt    <= nxt_cnt;
            an     <= nxt_an;
            seg    <= nxt_seg;
            active <= nxt_active;
            // copy needs pend_valid=1 and capture needs pend_valid=0, so the
            // two never collide on one edge.
            if (copy) begin
                pend_valid <= 1'b0;
            end else if (wr_valid && !pend_valid) begin
                pending    <= wr_data;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        blank_lz;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(.N_DIG(4), .DIV(4), .DEAD(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .blank_lz (blank_lz),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .an       (an),
        .seg      (seg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected-value model: 24-cycle frame, 6 cycles per digit (4 lit, 2 gap)
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h7E;  4'h1: return 7'h30;
            4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;
            4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;
            4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;
            4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    function automatic int hi_digit(input logic [15:0] v);
        int h = 0;
        for (int d = 0; d < 4; d++) if (v[d*4 +: 4] != 4'h0) h = d;
        return h;
    endfunction

    function automatic logic [3:0] exp_an(input logic [15:0] v, input int idx,
                                          input logic blz);
        int d = idx / 6;
        if (idx % 6 >= 4) return 4'hF;
        if (blz && d > hi_digit(v)) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int idx,
                                           input logic blz);
        int d = idx / 6;
        if (idx % 6 >= 4) return 7'h00;
        if (blz && d > hi_digit(v)) return 7'h00;
        return hex7(v[d*4 +: 4]);
    endfunction

    // driver: offer a value while IDLE; it transfers and is copied next edge
    task automatic drive_idle_load(input logic [15:0] v);
        wr_data  = v;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_hold got=%b want=0", wr_ready);
        end
        tick();
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_release got=%b want=1", wr_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; blank_lz = 1'b0; wr_valid = 1'b0; wr_data = '0;
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (an !== 4'hF || seg !== 7'h00 || wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset k=%0d an=%h seg=%h rdy=%b want F/00/1",
                         k, an, seg, wr_ready);
            end
            tick();
        end
    endtask

    task automatic test_scan_1234();
        drive_idle_load(16'h1234);
        en = 1'b1;
        for (int k = 0; k < 48; k++) begin
            tick();
            checks++;
            if (an !== exp_an(16'h1234, k % 24, 1'b0) ||
                seg !== exp_seg(16'h1234, k % 24, 1'b0)) begin
                errors++;
                $display("FAIL scan1234 k=%0d an=%h seg=%h want %h/%h", k, an, seg,
                         exp_an(16'h1234, k % 24, 1'b0), exp_seg(16'h1234, k % 24, 1'b0));
            end
        end
        en = 1'b0;
        tick();
        checks++;
        if (an !== 4'hF || seg !== 7'h00) begin
            errors++;
            $display("FAIL scan1234_off an=%h seg=%h want F/00", an, seg);
        end
    endtask

    task automatic test_blank_lz();
        blank_lz = 1'b1;
        drive_idle_load(16'h0005);
        en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            tick();
            checks++;
            if (an !== exp_an(16'h0005, k, 1'b1) || seg !== exp_seg(16'h0005, k, 1'b1)) begin
                errors++;
                $display("FAIL blank k=%0d an=%h seg=%h want %h/%h", k, an, seg,
                         exp_an(16'h0005, k, 1'b1), exp_seg(16'h0005, k, 1'b1));
            end
        end
        en = 1'b0;
        tick();
        blank_lz = 1'b0;
    endtask

    task automatic test_midframe_write();
        drive_idle_load(16'h1234);
        en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++;
            if (an !== exp_an(16'h1234, k % 24, 1'b0) ||
                seg !== exp_seg(16'h1234, k % 24, 1'b0)) begin
                errors++;
                $display("FAIL mid_pre k=%0d an=%h seg=%h", k, an, seg);
            end
        end
        // now at frame index 5; offer ABCD, then hold a second offer
        wr_data  = 16'hABCD;
        wr_valid = 1'b1;
        tick();
        wr_data = 16'h5555;
        for (int idx = 6; idx < 24; idx++) begin
            if (idx > 6) tick();
            checks++;
            if (an !== exp_an(16'h1234, idx, 1'b0) ||
                seg !== exp_seg(16'h1234, idx, 1'b0) || wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL mid_hold idx=%0d an=%h seg=%h rdy=%b want %h/%h/0",
                         idx, an, seg, wr_ready,
                         exp_an(16'h1234, idx, 1'b0), exp_seg(16'h1234, idx, 1'b0));
            end
        end
        wr_valid = 1'b0;
        for (int k = 0; k < 48; k++) begin
            tick();
            checks++;
            if (an !== exp_an(16'hABCD, k % 24, 1'b0) ||
                seg !== exp_seg(16'hABCD, k % 24, 1'b0) || wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_new k=%0d an=%h seg=%h rdy=%b want %h/%h/1",
                         k, an, seg, wr_ready,
                         exp_an(16'hABCD, k % 24, 1'b0), exp_seg(16'hABCD, k % 24, 1'b0));
            end
        end
    endtask

    task automatic test_en_drop();
        for (int k = 0; k <= 12; k++) tick();
        checks++;
        if (an !== 4'hB || seg !== 7'h1F) begin
            errors++;
            $display("FAIL drop_digit2 an=%h seg=%h want B/1F", an, seg);
        end
        en = 1'b0;
        tick();
        checks++;
        if (an !== 4'hF || seg !== 7'h00) begin
            errors++;
            $display("FAIL drop_off an=%h seg=%h want F/00", an, seg);
        end
        tick();
        en = 1'b1;
        tick();
        checks++;
        if (an !== 4'hE || seg !== 7'h3D) begin
            errors++;
            $display("FAIL drop_restart an=%h seg=%h want E/3D", an, seg);
        end
    endtask

    task automatic test_reset_midgap();
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (an !== 4'hF) begin
            errors++;
            $display("FAIL rstgap_in_gap an=%h want F", an);
        end
        wr_data  = 16'h8888;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstgap_pending rdy=%b want 0", wr_ready);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (an !== 4'hF || seg !== 7'h00 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstgap_reset an=%h seg=%h rdy=%b want F/00/1", an, seg, wr_ready);
        end
        reset = 1'b0;
        for (int k = 0; k < 24; k++) begin
            tick();
            checks++;
            if (an !== exp_an(16'h0000, k, 1'b0) || seg !== exp_seg(16'h0000, k, 1'b0)) begin
                errors++;
                $display("FAIL rstgap_frame k=%0d an=%h seg=%h want %h/%h", k, an, seg,
                         exp_an(16'h0000, k, 1'b0), exp_seg(16'h0000, k, 1'b0));
            end
        end
        en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_blank_lz();
        test_midframe_write();
        test_en_drop();
        test_reset_midgap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
